// File: rtl/edf_pkg.sv
// edf_pkg: shared types and helpers for the EDF deadline tracker.
// Optional feature macro: EDF_DEADLINE_MISS_EN (sticky per-line miss flag).
package edf_pkg;

  // Widest relative deadline the config register file can carry.
  localparam int DlMaxW = 32;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } line_state_e;

  typedef struct packed {
    logic              en;
    logic [DlMaxW-1:0] dl;
  } line_cfg_t;

  // Most negative signed time-to-deadline; counters saturate here.
  function automatic int PrioMin(input int width);
    return -(1 << (width - 1));
  endfunction

endpackage

// File: rtl/edf_deadline_cnt.sv
// edf_deadline_cnt: per-line pending state and signed deadline counter.
// Optional feature macro: EDF_DEADLINE_MISS_EN (sticky miss flag).
module edf_deadline_cnt
  import edf_pkg::*;
#(
  parameter int PrioWidth = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 tick_i,
  input  logic                 arrive_i,
  input  logic                 en_i,
  input  logic [PrioWidth-1:0] dl_i,
  input  logic                 claim_i,
  output logic                 pending_o,
  output logic [PrioWidth-1:0] cnt_o
`ifdef EDF_DEADLINE_MISS_EN
  ,
  output logic                 miss_o
`endif
);

  localparam logic [PrioWidth-1:0] CntMin =
    PrioWidth'(PrioMin(PrioWidth));
  localparam logic [PrioWidth-1:0] CntOne =
    PrioWidth'(1);

  line_state_e          state_q;
  logic [PrioWidth-1:0] cnt_q;
  logic                 load;
  logic                 clear;
  logic                 dec;
  logic                 sat;

  // A claim frees the line, so a same-cycle arrival may reload it.
  assign load  = arrive_i & en_i &
                 ((state_q == IDLE) | claim_i);
  assign clear = claim_i & (state_q == PENDING);
  assign dec   = tick_i & (state_q == PENDING);
  assign sat   = (cnt_q == CntMin);

  // Load beats claim beats tick; saturate instead of wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else if (load) begin
      state_q <= PENDING;
      cnt_q   <= dl_i;
    end else if (clear) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else if (dec && !sat) begin
      cnt_q   <= cnt_q - CntOne;
    end
  end

  assign pending_o = (state_q == PENDING);
  assign cnt_o     = cnt_q;

`ifdef EDF_DEADLINE_MISS_EN
  logic miss_q;

  // Sticky flag set when a tick crosses the deadline (0 -> -1).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      miss_q <= 1'b0;
    end else if (load || clear) begin
      miss_q <= 1'b0;
    end else if (dec && (cnt_q == '0)) begin
      miss_q <= 1'b1;
    end
  end

  assign miss_o = miss_q;
`endif

endmodule

// File: rtl/edf_deadline_tracker.sv
// edf_deadline_tracker: interrupt edge capture and deadline countdown.
// Optional feature macro: EDF_DEADLINE_MISS_EN (adds miss_o).
module edf_deadline_tracker
  import edf_pkg::*;
#(
  parameter  int NrInputs  = 32,
  parameter  int PrioWidth = 8,
  localparam int IdxWidth  = $clog2(NrInputs)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NrInputs-1:0]           irq_i,
  input  logic                          tick_i,
  input  logic                          cfg_we_i,
  input  logic [IdxWidth-1:0]           cfg_idx_i,
  input  logic                          cfg_en_i,
  input  logic [PrioWidth-1:0]          cfg_dl_i,
  input  logic                          claim_i,
  input  logic [IdxWidth-1:0]           claim_idx_i,
  output logic [NrInputs-1:0]           valid_o,
  output logic [NrInputs*PrioWidth-1:0] prio_o
`ifdef EDF_DEADLINE_MISS_EN
  ,
  output logic [NrInputs-1:0]           miss_o
`endif
);

  logic [NrInputs-1:0] irq_q;
  logic [NrInputs-1:0] edge_v;
  logic [NrInputs-1:0] claim_v;
  logic [NrInputs-1:0] en_v;
  logic [NrInputs-1:0] pend_v;
  logic [NrInputs-1:0] dl_unused;
  logic                msb_unused;
  line_cfg_t           cfg_q [NrInputs];

  // Previous irq level; sampled through reset so a level held
  // across reset release is not mistaken for a fresh edge.
  always_ff @(posedge clk_i) begin
    irq_q <= irq_i;
  end

  assign edge_v = irq_i & ~irq_q;

  // Config register file; the deadline MSB is dropped on write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NrInputs; i++) begin
        cfg_q[i] <= '0;
      end
    end else if (cfg_we_i) begin
      cfg_q[cfg_idx_i] <= '{
        en: cfg_en_i,
        dl: DlMaxW'(cfg_dl_i[PrioWidth-2:0])
      };
    end
  end

  assign msb_unused = cfg_dl_i[PrioWidth-1];

  for (genvar k = 0; k < NrInputs; k++) begin : g_line
    logic [PrioWidth-1:0] load_dl;

    assign claim_v[k] = claim_i &&
                        (claim_idx_i == IdxWidth'(k));
    assign en_v[k]    = cfg_q[k].en;
    assign load_dl    = {1'b0, cfg_q[k].dl[PrioWidth-2:0]};
    assign dl_unused[k] =
      ^cfg_q[k].dl[DlMaxW-1:PrioWidth-1];

`ifdef EDF_DEADLINE_MISS_EN
    edf_deadline_cnt #(
      .PrioWidth (PrioWidth)
    ) u_cnt (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .tick_i    (tick_i),
      .arrive_i  (edge_v[k]),
      .en_i      (en_v[k]),
      .dl_i      (load_dl),
      .claim_i   (claim_v[k]),
      .pending_o (pend_v[k]),
      .cnt_o     (prio_o[k*PrioWidth +: PrioWidth]),
      .miss_o    (miss_o[k])
    );
`else
    edf_deadline_cnt #(
      .PrioWidth (PrioWidth)
    ) u_cnt (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .tick_i    (tick_i),
      .arrive_i  (edge_v[k]),
      .en_i      (en_v[k]),
      .dl_i      (load_dl),
      .claim_i   (claim_v[k]),
      .pending_o (pend_v[k]),
      .cnt_o     (prio_o[k*PrioWidth +: PrioWidth])
    );
`endif
  end

  // Disabled lines keep counting but are hidden from the arbiter.
  assign valid_o = pend_v & en_v;

endmodule
